// File: rtl/alu_seq_ctrl.sv
// Purpose: micro-sequencer driving an 8-bit clocked ALU through LOAD/EXEC/CAPT for one requester.
// Latency: DONE appears ALU_LAT+3 cycles after the cycle in which START is presented.
// Backpressure: START is only looked at while idle; requests arriving while busy are dropped.
module alu_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opc,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] alu_q,
    output logic             isum,
    output logic             isub,
    output logic             iand,
    output logic             ior,
    output logic             ishl,
    output logic             ixor,
    output logic             ealu,
    output logic [WIDTH-1:0] dina,
    output logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    // Last EXEC count value; the counter is 4 bits since ALU_LAT tops out at 15.
    localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        CAPT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_q;
    logic [3:0] cnt;
    logic       accept;
    logic       illegal;

    // A request is either taken into the sequence or bounced immediately as illegal.
    assign accept  = (state == IDLE) && start && (opc <= OP_XOR);
    assign illegal = (state == IDLE) && start && (opc >  OP_XOR);
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; EXEC exits once the counter has covered ALU_LAT cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = EXEC;
            EXEC:    if (cnt == LAST_CNT) state_nxt = CAPT;
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/opcode latch, latency counter, result capture and one-cycle status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            dina   <= '0;
            din    <= '0;
            op_q   <= OP_SUM;
            cnt    <= 4'd0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                dina <= opa;
                din  <= opb;
                op_q <= opc;
            end
            if (illegal) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
            if (state == LOAD) begin
                cnt <= 4'd0;
            end
            if (state == EXEC) begin
                cnt <= cnt + 4'd1;
            end
            if (state == CAPT) begin
                result <= alu_q;
                done   <= 1'b1;
            end
        end
    end

    // Control word: everything inactive except during EXEC, where EALU and one select go low.
    always_comb begin
        isum = 1'b1;
        isub = 1'b1;
        iand = 1'b1;
        ior  = 1'b1;
        ishl = 1'b1;
        ixor = 1'b1;
        ealu = 1'b1;
        if (state == EXEC) begin
            ealu = 1'b0;
            case (op_q)
                OP_SUM:  isum = 1'b0;
                OP_SUB:  isub = 1'b0;
                OP_AND:  iand = 1'b0;
                OP_OR:   ior  = 1'b0;
                OP_SHL:  ishl = 1'b0;
                OP_XOR:  ixor = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Purpose: randomized and directed check of alu_seq_ctrl at ALU_LAT=1 and ALU_LAT=3 against a timeline model.
// Latency: model predicts BUSY/EALU/DONE windows from the accept cycle and the latency parameter.
// Backpressure: requests issued while busy must vanish without side effects.
module tb_alu_seq_ctrl;

    localparam int W = 8;
    localparam int LATS [2] = '{1, 3};

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   opc;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         start [2];
    logic [W-1:0] alu_q [2];
    logic         isum [2], isub [2], iand [2], ior [2], ishl [2], ixor [2], ealu [2];
    logic [W-1:0] dina [2], din [2], result [2];
    logic         busy [2], done [2], err [2];

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Reference model: per instance, the accept cycle and what the operation should yield.
    bit         m_active [2];
    int         m_e      [2];
    int         m_done   [2];
    int         m_errc   [2];
    logic [2:0] m_op     [2];
    logic [W-1:0] m_a [2], m_b [2], m_res [2], m_pend [2];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[0]), .opc(opc), .opa(opa), .opb(opb),
        .alu_q(alu_q[0]), .isum(isum[0]), .isub(isub[0]), .iand(iand[0]), .ior(ior[0]),
        .ishl(ishl[0]), .ixor(ixor[0]), .ealu(ealu[0]), .dina(dina[0]), .din(din[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .result(result[0])
    );

    alu_seq_ctrl #(.WIDTH(W), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start[1]), .opc(opc), .opa(opa), .opb(opb),
        .alu_q(alu_q[1]), .isum(isum[1]), .isub(isub[1]), .iand(iand[1]), .ior(ior[1]),
        .ishl(ishl[1]), .ixor(ixor[1]), .ealu(ealu[1]), .dina(dina[1]), .din(din[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .result(result[1])
    );

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    ref_op = a + b;
            3'd1:    ref_op = a - b;
            3'd2:    ref_op = a & b;
            3'd3:    ref_op = a | b;
            3'd4:    ref_op = a << 1;
            3'd5:    ref_op = a ^ b;
            default: ref_op = 8'hEE;
        endcase
    endfunction

    // Maps the active-low select lines back to an operation; anything but exactly one low is bogus.
    function automatic logic [2:0] dec_lines(input logic [5:0] l);
        case (l)
            6'b011111: dec_lines = 3'd0;
            6'b101111: dec_lines = 3'd1;
            6'b110111: dec_lines = 3'd2;
            6'b111011: dec_lines = 3'd3;
            6'b111101: dec_lines = 3'd4;
            6'b111110: dec_lines = 3'd5;
            default:   dec_lines = 3'd7;
        endcase
    endfunction

    // Behavioural clocked ALU: registers the selected function whenever EALU is low.
    always @(posedge clk) begin
        if (!ealu[0])
            alu_q[0] <= ref_op(dec_lines({isum[0], isub[0], iand[0], ior[0], ishl[0], ixor[0]}),
                               dina[0], din[0]);
        if (!ealu[1])
            alu_q[1] <= ref_op(dec_lines({isum[1], isub[1], iand[1], ior[1], ishl[1], ixor[1]}),
                               dina[1], din[1]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    // Advance the model for one rising edge using the inputs the DUT also sees.
    task automatic model_edge(input int i);
        int  lat;
        bit  idle;
        lat = LATS[i];
        if (rst) begin
            m_active[i] = 1'b0;
            m_done[i]   = -1;
            m_errc[i]   = -1;
            m_res[i]    = '0;
            m_a[i]      = '0;
            m_b[i]      = '0;
        end else begin
            if (m_active[i] && n == m_done[i]) m_res[i] = m_pend[i];
            idle = !m_active[i] || (n > m_e[i] + lat + 2);
            if (idle && start[i]) begin
                if (opc <= 3'd5) begin
                    m_active[i] = 1'b1;
                    m_e[i]      = n;
                    m_done[i]   = n + lat + 2;
                    m_op[i]     = opc;
                    m_a[i]      = opa;
                    m_b[i]      = opb;
                    m_pend[i]   = ref_op(opc, opa, opb);
                end else begin
                    m_errc[i] = n;
                end
            end
        end
    endtask

    task automatic check_all(input int i);
        int         lat;
        bit         e_busy, e_ex, e_done;
        logic [6:0] onehot, e_cw, cw;
        lat    = LATS[i];
        e_busy = m_active[i] && (n >= m_e[i]) && (n <= m_e[i] + lat + 1);
        e_ex   = m_active[i] && (n >= m_e[i] + 1) && (n <= m_e[i] + lat);
        e_done = (m_active[i] && n == m_done[i]) || (n == m_errc[i]);
        onehot = 7'b1000000 >> m_op[i];
        e_cw   = e_ex ? ~(onehot | 7'b0000001) : 7'h7F;
        cw     = {isum[i], isub[i], iand[i], ior[i], ishl[i], ixor[i], ealu[i]};
        check($sformatf("L%0d busy", lat), 32'(busy[i]), 32'(e_busy));
        check($sformatf("L%0d ctrl", lat), 32'(cw), 32'(e_cw));
        check($sformatf("L%0d done", lat), 32'(done[i]), 32'(e_done));
        check($sformatf("L%0d err", lat), 32'(err[i]), 32'(n == m_errc[i]));
        check($sformatf("L%0d result", lat), 32'(result[i]), 32'(m_res[i]));
        check($sformatf("L%0d dina", lat), 32'(dina[i]), 32'(m_a[i]));
        check($sformatf("L%0d din", lat), 32'(din[i]), 32'(m_b[i]));
    endtask

    // One clock: edge -> model update, falling edge -> compare both instances.
    task automatic step();
        @(posedge clk);
        n++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_all(0);
        check_all(1);
    endtask

    task automatic req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
        start[i] = 1'b1;
        opc      = op;
        opa      = a;
        opb      = b;
        step();
        start[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i]    = 1'b0;
            m_active[i] = 1'b0;
            m_e[i]      = -100;
            m_done[i]   = -1;
            m_errc[i]   = -1;
            m_op[i]     = 3'd0;
            m_pend[i]   = '0;
        end
        rst = 1'b1;
        opc = 3'd0;
        opa = '0;
        opb = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();

        // SUM, then the remaining legal ops back-to-back, each issued in the prior DONE cycle.
        req(0, 3'd0, 8'h03, 8'h01);
        repeat (3) step();
        for (int k = 1; k <= 5; k++) begin
            req(0, 3'(k), 8'h03, 8'h01);
            repeat (3) step();
        end
        check("xor result", 32'(result[0]), 32'h02);

        // Illegal opcode: immediate DONE+ERR, result retained.
        req(0, 3'd6, 8'h55, 8'h66);
        step();
        check("illegal keeps result", 32'(result[0]), 32'h02);

        // Interference: requests while busy must not disturb anything.
        req(0, 3'd0, 8'h03, 8'h01);
        start[0] = 1'b1;
        opc      = 3'd1;
        opa      = 8'hFF;
        repeat (3) step();
        start[0] = 1'b0;
        repeat (2) step();
        check("interference result", 32'(result[0]), 32'h04);

        // Reset in the middle of EXEC aborts without a DONE.
        req(0, 3'd0, 8'h03, 8'h01);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();

        // Longer latency instance: SUM again.
        req(1, 3'd0, 8'h03, 8'h01);
        repeat (6) step();
        check("lat3 sum result", 32'(result[1]), 32'h04);

        // Random traffic on both instances with occasional resets.
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 79) == 0);
            start[0] = ($urandom_range(0, 2) != 0);
            start[1] = ($urandom_range(0, 2) != 0);
            opc      = 3'($urandom_range(0, 7));
            opa      = 8'($urandom);
            opb      = 8'($urandom);
            step();
        end
        rst      = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
